fsbm_seq_ctrl: RTL and testbench

//  Parametrised control sequencer for the full-search block-matching datapath.
//  - Drives the PE array, reference/candidate/column memories and the raw-pixel input register.
//  - Generalises the fixed 24-cycle schedule to block size BLK_N, a configurable period and a configurable column-load slot.
//  - Adds busy/row_done status and an optional row counter with a frame_done pulse.

---
 rtl/fsbm_pkg.sv | 36 +++
 rtl/fsbm_slot_cnt.sv | 48 ++++
 rtl/fsbm_seq_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_fsbm_seq_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fsbm_pkg.sv
// Shared types and helpers for the full-search block-matching sequencer.
// Holds the sequencer state encoding, default geometry constants and the
// ctr_word schedule used while the datapath is running.
package fsbm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FIRST0,
    FIRST1,
    RUN
  } fsbm_state_e;

  localparam int DEF_WORD_WIDTH = 8;
  localparam int DEF_LANES      = 4;
  localparam int DEF_BLK_N      = 16;
  localparam int DEF_PERIOD     = 24;

  // PE select word for a RUN slot: all ones on slot 0 (caller truncates to
  // its ctr_word width), a rising 1..blk_n-2 sweep over the last blk_n-2
  // slots of the period, zero elsewhere.
  function automatic int unsigned slot_to_ctr(input int unsigned slot,
                                               input int unsigned period,
                                               input int unsigned blk_n);
    int unsigned first_slot;
    first_slot = period - blk_n + 2;
    if (slot == 0) begin
      return 32'hFFFF_FFFF;
    end
    if ((slot >= first_slot) && (slot <= period - 1)) begin
      return slot - (period - blk_n + 1);
    end
    return 0;
  endfunction

endpackage

// File: rtl/fsbm_slot_cnt.sv
// Period slot counter for the block-matching sequencer.
// Counts 0..PERIOD-1 and wraps; a synchronous clear forces slot 0. The
// next-slot value is exported so the owner can register decoded outputs
// in the same cycle the counter itself updates.
module fsbm_slot_cnt
  import fsbm_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      advance,
  output logic [$clog2(PERIOD)-1:0] slot_next
);

  localparam int SW = $clog2(PERIOD);
  localparam logic [SW-1:0] SLOT_LAST = SW'(PERIOD - 1);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  // Next slot: clear wins, otherwise step with wrap at the end of the period.
  always_comb begin
    slot_d = slot_q;
    if (clear) begin
      slot_d = '0;
    end else if (advance) begin
      if (slot_q == SLOT_LAST) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + SW'(1);
      end
    end
  end

  // Slot register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_next = slot_d;

endmodule

// File: rtl/fsbm_seq_ctrl.sv
// Control sequencer for the full-search block-matching datapath.
// Drives PE enables/select, reference/candidate/column memory enables and
// the raw-pixel input register. All outputs are registered from the
// next-state values, so they line up with the state/counter registers.
// Optional feature macro: FSBM_FRAME_DONE_EN adds a row counter and a
// frame_done pulse on every ROWS-th row_done; otherwise frame_done is 0.
module fsbm_seq_ctrl
  import fsbm_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int BLK_N      = DEF_BLK_N,
  parameter int PERIOD     = DEF_PERIOD,
  parameter int INIT_LEN   = 8,
  parameter int COL_SLOT   = 6,
  parameter int ROWS       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_init,
  input  logic [WORD_WIDTH*LANES-1:0]   input_raw,
  output logic [WORD_WIDTH*LANES-1:0]   input_raw_saved,
  output logic [$clog2(BLK_N)-1:0]      ctr_word,
  output logic                          en_pe,
  output logic                          mem_ref_en,
  output logic                          mem_cand_en,
  output logic                          mem_col_en,
  output logic                          mem_init_mode,
  output logic                          busy,
  output logic                          row_done,
  output logic                          frame_done
);

  localparam int CW = $clog2(BLK_N);
  localparam int SW = $clog2(PERIOD);
  localparam int IW = $clog2(INIT_LEN + 1);

  localparam logic [SW-1:0] SLOT_PE_FIRST = SW'(PERIOD - BLK_N + 2);
  localparam logic [SW-1:0] SLOT_REF_LAST = SW'(PERIOD - 2);
  localparam logic [SW-1:0] SLOT_LAST     = SW'(PERIOD - 1);
  localparam logic [SW-1:0] SLOT_COL      = SW'(COL_SLOT);
  localparam logic [IW-1:0] ICNT_SAT      = IW'(INIT_LEN);
  localparam logic [IW-1:0] ICNT_COL      = IW'(COL_SLOT);

  if (PERIOD < BLK_N + 6) begin : g_chk_period
    $error("fsbm_seq_ctrl: PERIOD must be at least BLK_N+6");
  end
  if ((COL_SLOT < 2) || (COL_SLOT >= INIT_LEN)) begin : g_chk_col
    $error("fsbm_seq_ctrl: COL_SLOT must lie in 2..INIT_LEN-1");
  end
  if (ROWS < 1) begin : g_chk_rows
    $error("fsbm_seq_ctrl: ROWS must be at least 1");
  end

  fsbm_state_e state_q, state_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [SW-1:0] slot_d;
  logic          slot_clear;
  logic          slot_adv;

  logic [WORD_WIDTH*LANES-1:0] input_raw_saved_q;
  logic [CW-1:0] ctr_word_q, ctr_word_d;
  logic en_pe_q, en_pe_d;
  logic mem_ref_en_q, mem_ref_en_d;
  logic mem_cand_en_q, mem_cand_en_d;
  logic mem_col_en_q, mem_col_en_d;
  logic mem_init_mode_q, mem_init_mode_d;
  logic busy_q, busy_d;
  logic row_done_q, row_done_d;
  logic frame_done_q, frame_done_d;

  // Next state: en_init pulls IDLE/RUN into INIT; dropping it starts the first period.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en_init) state_d = INIT;
      INIT:    if (!en_init) state_d = FIRST0;
      FIRST0:  state_d = FIRST1;
      FIRST1:  state_d = RUN;
      RUN:     if (en_init) state_d = INIT;
      default: state_d = IDLE;
    endcase
  end

  // Init counter restarts on INIT entry and saturates at INIT_LEN.
  always_comb begin
    icnt_d = '0;
    if ((state_d == INIT) && (state_q == INIT)) begin
      icnt_d = (icnt_q == ICNT_SAT) ? icnt_q : icnt_q + IW'(1);
    end
  end

  assign slot_clear = (state_d == IDLE) || (state_d == INIT) || (state_d == FIRST0);
  assign slot_adv   = (state_d == FIRST1) || (state_d == RUN);

  fsbm_slot_cnt #(
    .PERIOD (PERIOD)
  ) u_slot_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (slot_clear),
    .advance   (slot_adv),
    .slot_next (slot_d)
  );

  // Output decode from the upcoming state, init count and slot.
  always_comb begin
    ctr_word_d      = '0;
    en_pe_d         = 1'b0;
    mem_ref_en_d    = 1'b0;
    mem_cand_en_d   = 1'b0;
    mem_col_en_d    = 1'b0;
    mem_init_mode_d = 1'b0;
    row_done_d      = 1'b0;
    busy_d          = (state_d != IDLE);
    unique case (state_d)
      INIT: begin
        mem_ref_en_d    = 1'b1;
        mem_init_mode_d = 1'b1;
        if (icnt_d == '0) begin
          ctr_word_d = '1;
          en_pe_d    = 1'b1;
        end else if (icnt_d == IW'(1)) begin
          en_pe_d = 1'b1;
        end
        mem_col_en_d = (icnt_d == ICNT_COL);
      end
      FIRST0: begin
        mem_cand_en_d   = 1'b1;
        mem_init_mode_d = 1'b1;
      end
      FIRST1: begin
        mem_cand_en_d = 1'b1;
      end
      RUN: begin
        ctr_word_d    = CW'(slot_to_ctr(32'(slot_d), PERIOD, BLK_N));
        en_pe_d       = (slot_d <= SW'(1)) || (slot_d >= SLOT_PE_FIRST);
        mem_cand_en_d = (slot_d <= SW'(3));
        mem_ref_en_d  = (slot_d >= SW'(4)) && (slot_d <= SLOT_REF_LAST);
        mem_col_en_d  = (slot_d == SLOT_COL);
        row_done_d    = (slot_d == SLOT_LAST);
      end
      default: begin
      end
    endcase
  end

`ifdef FSBM_FRAME_DONE_EN
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [RW-1:0] row_cnt_q, row_cnt_d;

  // Row counter: clears on en_init, wraps on the ROWS-th row and flags the frame.
  always_comb begin
    row_cnt_d    = row_cnt_q;
    frame_done_d = 1'b0;
    if (en_init) begin
      row_cnt_d = '0;
    end else if (row_done_d) begin
      if (row_cnt_q == ROW_LAST) begin
        row_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + RW'(1);
      end
    end
  end

  // Row counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_cnt_q <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
    end
  end
`else
  assign frame_done_d = 1'b0;
`endif

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      icnt_q            <= '0;
      input_raw_saved_q <= '0;
      ctr_word_q        <= '0;
      en_pe_q           <= 1'b0;
      mem_ref_en_q      <= 1'b0;
      mem_cand_en_q     <= 1'b0;
      mem_col_en_q      <= 1'b0;
      mem_init_mode_q   <= 1'b0;
      busy_q            <= 1'b0;
      row_done_q        <= 1'b0;
      frame_done_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      icnt_q            <= icnt_d;
      input_raw_saved_q <= input_raw;
      ctr_word_q        <= ctr_word_d;
      en_pe_q           <= en_pe_d;
      mem_ref_en_q      <= mem_ref_en_d;
      mem_cand_en_q     <= mem_cand_en_d;
      mem_col_en_q      <= mem_col_en_d;
      mem_init_mode_q   <= mem_init_mode_d;
      busy_q            <= busy_d;
      row_done_q        <= row_done_d;
      frame_done_q      <= frame_done_d;
    end
  end

  assign input_raw_saved = input_raw_saved_q;
  assign ctr_word        = ctr_word_q;
  assign en_pe           = en_pe_q;
  assign mem_ref_en      = mem_ref_en_q;
  assign mem_cand_en     = mem_cand_en_q;
  assign mem_col_en      = mem_col_en_q;
  assign mem_init_mode   = mem_init_mode_q;
  assign busy            = busy_q;
  assign row_done        = row_done_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_fsbm_seq_ctrl.sv
// Directed testbench for fsbm_seq_ctrl.
// Two instances share stimulus: the default geometry (BLK_N=16, PERIOD=24)
// and a small one (BLK_N=8, PERIOD=16); both use ROWS=4. Outputs are packed
// as {ctr[3:0], en_pe, ref, cand, col, init_mode, busy, row_done, frame_done}.
module tb_fsbm_seq_ctrl;

`ifdef FSBM_FRAME_DONE_EN
  localparam bit FRAME_EN = 1'b1;
`else
  localparam bit FRAME_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en_init;
  logic [31:0] input_raw;

  logic [31:0] saved1, saved2;
  logic [3:0]  ctr1;
  logic [2:0]  ctr2;
  logic en1, ref1, cand1, col1, mode1, busy1, rd1, fd1;
  logic en2, ref2, cand2, col2, mode2, busy2, rd2, fd2;

  int checkCount = 0;
  int errorCount = 0;
  int rows1 = 0;
  int rows2 = 0;

  fsbm_seq_ctrl #(
    .WORD_WIDTH (8), .LANES (4), .BLK_N (16), .PERIOD (24),
    .INIT_LEN (8), .COL_SLOT (6), .ROWS (4)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .en_init (en_init), .input_raw (input_raw),
    .input_raw_saved (saved1), .ctr_word (ctr1), .en_pe (en1),
    .mem_ref_en (ref1), .mem_cand_en (cand1), .mem_col_en (col1),
    .mem_init_mode (mode1), .busy (busy1), .row_done (rd1), .frame_done (fd1)
  );

  fsbm_seq_ctrl #(
    .WORD_WIDTH (8), .LANES (4), .BLK_N (8), .PERIOD (16),
    .INIT_LEN (8), .COL_SLOT (6), .ROWS (4)
  ) dut2 (
    .clk (clk), .rst_n (rst_n), .en_init (en_init), .input_raw (input_raw),
    .input_raw_saved (saved2), .ctr_word (ctr2), .en_pe (en2),
    .mem_ref_en (ref2), .mem_cand_en (cand2), .mem_col_en (col2),
    .mem_init_mode (mode2), .busy (busy2), .row_done (rd2), .frame_done (fd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pack(input logic [3:0] ctr, input logic en,
                                       input logic rf, input logic cd,
                                       input logic cl, input logic md,
                                       input logic bz, input logic rd,
                                       input logic fd);
    return {ctr, en, rf, cd, cl, md, bz, rd, fd};
  endfunction

  function automatic logic [11:0] obs1();
    return pack(ctr1, en1, ref1, cand1, col1, mode1, busy1, rd1, fd1);
  endfunction

  function automatic logic [11:0] obs2();
    return pack({1'b0, ctr2}, en2, ref2, cand2, col2, mode2, busy2, rd2, fd2);
  endfunction

  // Expected INIT outputs for init-count k (k already saturated by caller or not; only 0,1,6 matter).
  function automatic logic [11:0] expInit(input int k, input logic [3:0] ones);
    return pack((k == 0) ? ones : 4'h0, k <= 1, 1'b1, 1'b0, k == 6,
                1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  // Expected RUN outputs for slot s of a period p with block size b.
  function automatic logic [11:0] expRun(input int s, input int p, input int b,
                                         input logic [3:0] ones, input logic fd);
    logic [3:0] ctr;
    if (s == 0)                ctr = ones;
    else if (s >= p - b + 2)   ctr = 4'(s - (p - b + 1));
    else                       ctr = 4'h0;
    return pack(ctr, (s <= 1) || (s >= p - b + 2), (s >= 4) && (s <= p - 2),
                s <= 3, s == 6, 1'b0, 1'b1, s == p - 1, fd);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [31:0] raw);
    rst_n     = r;
    en_init   = e;
    input_raw = raw;
    @(posedge clk);
    #1;
  endtask

  // Leaves INIT and walks the running schedule up to cycle lastC (FIRST0 = cycle 0).
  task automatic runFrom(input int lastC, input string phase);
    logic f1, f2;
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput({phase, " first0 d1"}, 32'(obs1()), 32'(pack(4'h0, 0, 0, 1, 0, 1, 1, 0, 0)));
    checkOutput({phase, " first0 d2"}, 32'(obs2()), 32'(pack(4'h0, 0, 0, 1, 0, 1, 1, 0, 0)));
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput({phase, " first1 d1"}, 32'(obs1()), 32'(pack(4'h0, 0, 0, 1, 0, 0, 1, 0, 0)));
    checkOutput({phase, " first1 d2"}, 32'(obs2()), 32'(pack(4'h0, 0, 0, 1, 0, 0, 1, 0, 0)));
    for (int c = 2; c <= lastC; c++) begin
      applyStimulus(1'b1, 1'b0, 32'(c));
      f1 = 1'b0;
      f2 = 1'b0;
      if ((c % 24) == 23) begin
        rows1++;
        if (rows1 == 4) begin rows1 = 0; f1 = FRAME_EN; end
      end
      if ((c % 16) == 15) begin
        rows2++;
        if (rows2 == 4) begin rows2 = 0; f2 = FRAME_EN; end
      end
      checkOutput($sformatf("%s run d1 c%0d", phase, c), 32'(obs1()),
                  32'(expRun(c % 24, 24, 16, 4'hF, f1)));
      checkOutput($sformatf("%s run d2 c%0d", phase, c), 32'(obs2()),
                  32'(expRun(c % 16, 16, 8, 4'h7, f2)));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en_init   = 1'b1;
    input_raw = 32'h0;

    // Reset held with en_init high: everything zero.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF);
    end
    checkOutput("reset outs d1", 32'(obs1()), 32'h0);
    checkOutput("reset outs d2", 32'(obs2()), 32'h0);
    checkOutput("reset saved", saved1, 32'h0);

    // Long init: icnt 0..8 then saturated.
    for (int k = 0; k < 73; k++) begin
      applyStimulus(1'b1, 1'b1, 32'hA500_0000 + 32'(k));
      checkOutput($sformatf("init d1 k%0d", k), 32'(obs1()), 32'(expInit(k, 4'hF)));
      checkOutput($sformatf("init d2 k%0d", k), 32'(obs2()), 32'(expInit(k, 4'h7)));
      if ((k % 24) == 0) begin
        checkOutput($sformatf("saved k%0d", k), saved1, 32'hA500_0000 + 32'(k));
      end
    end

    // First run up to dut1 RUN slot 15 of the sixth period.
    rows1 = 0;
    rows2 = 0;
    runFrom(135, "run1");

    // Abort at slot 15: straight back into INIT, row counters cleared.
    applyStimulus(1'b1, 1'b1, 32'h0);
    rows1 = 0;
    rows2 = 0;
    checkOutput("abort d1", 32'(obs1()), 32'(expInit(0, 4'hF)));
    checkOutput("abort d2", 32'(obs2()), 32'(expInit(0, 4'h7)));

    // Second run covers the 4th row of dut1 (cycle 95 from FIRST0).
    runFrom(99, "run2");

    // Reset mid-run, then release with en_init low: IDLE, not busy.
    applyStimulus(1'b0, 1'b0, 32'h1234_5678);
    checkOutput("midreset d1", 32'(obs1()), 32'h0);
    checkOutput("midreset saved", saved2, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h1234_5678);
    checkOutput("idle d1", 32'(obs1()), 32'h0);
    checkOutput("idle d2", 32'(obs2()), 32'h0);
    checkOutput("idle saved", saved1, 32'h1234_5678);
    applyStimulus(1'b1, 1'b1, 32'h0);
    checkOutput("reinit d1", 32'(obs1()), 32'(expInit(0, 4'hF)));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
